// File: rtl/pipeline_sequencer_pkg.sv
// Shared command codes, state encodings and opcodes for the pipeline run-control sequencer.
package pipeline_sequencer_pkg;

   typedef logic [1:0] seq_cmd_t;

   localparam seq_cmd_t SEQ_CMD_RUN   = 2'b00;
   localparam seq_cmd_t SEQ_CMD_STEP  = 2'b01;
   localparam seq_cmd_t SEQ_CMD_PAUSE = 2'b10;
   localparam seq_cmd_t SEQ_CMD_CLEAR = 2'b11;

   localparam logic [2:0] SEQ_ST_IDLE     = 3'd0;
   localparam logic [2:0] SEQ_ST_RUN      = 3'd1;
   localparam logic [2:0] SEQ_ST_STEP     = 3'd2;
   localparam logic [2:0] SEQ_ST_DRAIN    = 3'd3;
   localparam logic [2:0] SEQ_ST_HALTED   = 3'd4;
   localparam logic [2:0] SEQ_ST_CLEARING = 3'd5;

   localparam logic [5:0] OPCODE_HALT = 6'b111111;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Command handshake between the debug unit (master) and the run-control sequencer (slave).
interface pipeline_sequencer_if;
   import pipeline_sequencer_pkg::*;

   logic     cmd_valid;
   seq_cmd_t cmd;
   logic     cmd_ready;

   modport master (output cmd_valid, output cmd, input cmd_ready);
   modport slave  (input cmd_valid, input cmd, output cmd_ready);

endinterface

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear has priority.
module pipeline_sequencer_sat_counter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              clr,
   output logic [DATA_W-1:0] count
);

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= sat_inc(count);
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control FSM: free-run, single-step, pause, HALT drain and clear for the pipeline.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_sequencer_if.slave  cmd_bus,
   input  logic                 halt_detected,
   output logic                 pipe_enable,
   output logic                 pc_enable,
   output logic                 if_id_flush,
   output logic                 soft_reset,
   output logic                 halted,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] cycle_count
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   logic [2:0]    st;
   logic [2:0]    st_next;
   logic [DW-1:0] drain_cnt;
   logic          cmd_ready;
   logic          cmd_accept;

   assign cmd_ready         = (st == SEQ_ST_IDLE) || (st == SEQ_ST_RUN) || (st == SEQ_ST_HALTED);
   assign cmd_bus.cmd_ready = cmd_ready;
   assign cmd_accept        = cmd_bus.cmd_valid && cmd_ready;

   always_comb begin
      st_next = st;
      case (st)
         SEQ_ST_IDLE: begin
            if (cmd_accept) begin
               case (cmd_bus.cmd)
                  SEQ_CMD_RUN:   st_next = SEQ_ST_RUN;
                  SEQ_CMD_STEP:  st_next = SEQ_ST_STEP;
                  SEQ_CMD_CLEAR: st_next = SEQ_ST_CLEARING;
                  default:       st_next = SEQ_ST_IDLE;
               endcase
            end
         end
         SEQ_ST_RUN: begin
            // A HALT in ID overrides any command presented in the same cycle.
            if (halt_detected)
               st_next = SEQ_ST_DRAIN;
            else if (cmd_accept && cmd_bus.cmd == SEQ_CMD_PAUSE)
               st_next = SEQ_ST_IDLE;
            else if (cmd_accept && cmd_bus.cmd == SEQ_CMD_CLEAR)
               st_next = SEQ_ST_CLEARING;
         end
         SEQ_ST_STEP:
            st_next = halt_detected ? SEQ_ST_DRAIN : SEQ_ST_IDLE;
         SEQ_ST_DRAIN:
            if (drain_cnt == '0) st_next = SEQ_ST_HALTED;
         SEQ_ST_HALTED:
            if (cmd_accept && cmd_bus.cmd == SEQ_CMD_CLEAR) st_next = SEQ_ST_CLEARING;
         SEQ_ST_CLEARING:
            st_next = SEQ_ST_IDLE;
         default:
            st_next = SEQ_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         st <= SEQ_ST_IDLE;
      else
         st <= st_next;
   end

   // Drain counter loads on DRAIN entry so DRAIN spans exactly DRAIN_CYCLES cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         drain_cnt <= '0;
      else if (st != SEQ_ST_DRAIN && st_next == SEQ_ST_DRAIN)
         drain_cnt <= DW'(DRAIN_CYCLES - 1);
      else if (st == SEQ_ST_DRAIN && drain_cnt != '0)
         drain_cnt <= drain_cnt - 1'b1;
   end

   assign pipe_enable = (st == SEQ_ST_RUN) || (st == SEQ_ST_STEP) || (st == SEQ_ST_DRAIN);
   assign pc_enable   = (st == SEQ_ST_RUN) || (st == SEQ_ST_STEP);
   assign if_id_flush = (st == SEQ_ST_DRAIN);
   assign soft_reset  = (st == SEQ_ST_CLEARING);
   assign halted      = (st == SEQ_ST_HALTED);
   assign state       = st;

   pipeline_sequencer_sat_counter #(.DATA_W(CNT_WIDTH)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (pipe_enable),
      .clr   (soft_reset),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: vector table plus hand sequences for drain, reset and saturation.
module tb_pipeline_sequencer;
   import pipeline_sequencer_pkg::*;

   localparam logic [5:0] F_IDLE  = 6'b000001;
   localparam logic [5:0] F_RUN   = 6'b110001;
   localparam logic [5:0] F_STEP  = 6'b110000;
   localparam logic [5:0] F_DRAIN = 6'b101000;
   localparam logic [5:0] F_HALT  = 6'b000011;
   localparam logic [5:0] F_CLR   = 6'b000100;

   typedef struct {
      logic       v;
      logic [1:0] c;
      logic       h;
      logic [2:0] st;
      logic [5:0] fl;
      logic [31:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt_detected;
   logic        pipe_enable, pc_enable, if_id_flush, soft_reset, halted;
   logic [2:0]  state;
   logic [31:0] cycle_count;

   logic        s_halt;
   logic        s_pipe, s_pc, s_flush, s_soft, s_halted;
   logic [2:0]  s_state;
   logic [3:0]  s_count;

   int checks = 0;
   int errors = 0;

   pipeline_sequencer_if bus ();
   pipeline_sequencer_if sbus ();

   pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_WIDTH(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_bus       (bus.slave),
      .halt_detected (halt_detected),
      .pipe_enable   (pipe_enable),
      .pc_enable     (pc_enable),
      .if_id_flush   (if_id_flush),
      .soft_reset    (soft_reset),
      .halted        (halted),
      .state         (state),
      .cycle_count   (cycle_count)
   );

   pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_WIDTH(4)) dut_sat (
      .clk           (clk),
      .reset         (reset),
      .cmd_bus       (sbus.slave),
      .halt_detected (s_halt),
      .pipe_enable   (s_pipe),
      .pc_enable     (s_pc),
      .if_id_flush   (s_flush),
      .soft_reset    (s_soft),
      .halted        (s_halted),
      .state         (s_state),
      .cycle_count   (s_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input logic [1:0] c, input logic h,
                               input logic [2:0] st, input logic [5:0] fl, input int cnt);
      vec_t r;
      r.v = v; r.c = c; r.h = h; r.st = st; r.fl = fl; r.cnt = 32'(cnt);
      return r;
   endfunction

   function automatic logic [8:0] obs();
      return {state, pipe_enable, pc_enable, if_id_flush, soft_reset, halted, bus.cmd_ready};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] c, input logic h);
      bus.cmd_valid = v;
      bus.cmd       = c;
      halt_detected = h;
   endtask

   vec_t vecs[$];

   initial begin
      reset = 1'b1;
      drive(1'b0, 2'b00, 1'b0);
      sbus.cmd_valid = 1'b0;
      sbus.cmd       = SEQ_CMD_RUN;
      s_halt         = 1'b0;

      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_IDLE,     F_IDLE,  0));
      vecs.push_back(mk(1, SEQ_CMD_RUN,   0, SEQ_ST_IDLE,     F_IDLE,  0));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_RUN,      F_RUN,   0));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_RUN,      F_RUN,   1));
      vecs.push_back(mk(1, SEQ_CMD_RUN,   0, SEQ_ST_RUN,      F_RUN,   2));
      vecs.push_back(mk(1, SEQ_CMD_STEP,  0, SEQ_ST_RUN,      F_RUN,   3));
      vecs.push_back(mk(1, SEQ_CMD_PAUSE, 1, SEQ_ST_RUN,      F_RUN,   4));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_DRAIN,    F_DRAIN, 5));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_DRAIN,    F_DRAIN, 6));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_DRAIN,    F_DRAIN, 7));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_DRAIN,    F_DRAIN, 8));
      vecs.push_back(mk(1, SEQ_CMD_RUN,   0, SEQ_ST_HALTED,   F_HALT,  9));
      vecs.push_back(mk(1, SEQ_CMD_STEP,  0, SEQ_ST_HALTED,   F_HALT,  9));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   1, SEQ_ST_HALTED,   F_HALT,  9));
      vecs.push_back(mk(1, SEQ_CMD_CLEAR, 0, SEQ_ST_HALTED,   F_HALT,  9));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_CLEARING, F_CLR,   9));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_IDLE,     F_IDLE,  0));
      vecs.push_back(mk(1, SEQ_CMD_PAUSE, 0, SEQ_ST_IDLE,     F_IDLE,  0));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   1, SEQ_ST_IDLE,     F_IDLE,  0));
      vecs.push_back(mk(1, SEQ_CMD_STEP,  0, SEQ_ST_IDLE,     F_IDLE,  0));
      vecs.push_back(mk(1, SEQ_CMD_STEP,  0, SEQ_ST_STEP,     F_STEP,  0));
      vecs.push_back(mk(1, SEQ_CMD_STEP,  0, SEQ_ST_IDLE,     F_IDLE,  1));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_STEP,     F_STEP,  1));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_IDLE,     F_IDLE,  2));
      vecs.push_back(mk(1, SEQ_CMD_STEP,  0, SEQ_ST_IDLE,     F_IDLE,  2));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   1, SEQ_ST_STEP,     F_STEP,  2));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_DRAIN,    F_DRAIN, 3));
      vecs.push_back(mk(1, SEQ_CMD_CLEAR, 0, SEQ_ST_DRAIN,    F_DRAIN, 4));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_DRAIN,    F_DRAIN, 5));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_DRAIN,    F_DRAIN, 6));
      vecs.push_back(mk(1, SEQ_CMD_CLEAR, 0, SEQ_ST_HALTED,   F_HALT,  7));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_CLEARING, F_CLR,   7));
      vecs.push_back(mk(1, SEQ_CMD_RUN,   0, SEQ_ST_IDLE,     F_IDLE,  0));
      vecs.push_back(mk(1, SEQ_CMD_CLEAR, 0, SEQ_ST_RUN,      F_RUN,   0));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_CLEARING, F_CLR,   1));
      vecs.push_back(mk(1, SEQ_CMD_CLEAR, 0, SEQ_ST_IDLE,     F_IDLE,  0));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_CLEARING, F_CLR,   0));
      vecs.push_back(mk(0, SEQ_CMD_RUN,   0, SEQ_ST_IDLE,     F_IDLE,  0));

      repeat (2) @(negedge clk);
      check("reset_out", 64'(obs()), 64'({SEQ_ST_IDLE, F_IDLE}));
      check("reset_cnt", 64'(cycle_count), 64'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].c, vecs[i].h);
         check($sformatf("vec%0d_out", i), 64'(obs()), 64'({vecs[i].st, vecs[i].fl}));
         check($sformatf("vec%0d_cnt", i), 64'(cycle_count), 64'(vecs[i].cnt));
         @(negedge clk);
      end

      // Free run for ten counted cycles, then pause.
      drive(1'b1, SEQ_CMD_RUN, 1'b0);
      @(negedge clk);
      drive(1'b0, SEQ_CMD_RUN, 1'b0);
      repeat (9) @(negedge clk);
      check("run9_cnt", 64'(cycle_count), 64'd9);
      drive(1'b1, SEQ_CMD_PAUSE, 1'b0);
      @(negedge clk);
      drive(1'b0, SEQ_CMD_RUN, 1'b0);
      check("pause_out", 64'(obs()), 64'({SEQ_ST_IDLE, F_IDLE}));
      check("pause_cnt", 64'(cycle_count), 64'd10);
      @(negedge clk);
      check("pause_hold_cnt", 64'(cycle_count), 64'd10);

      // HALT timing: count enabled cycles after the halt cycle.
      drive(1'b1, SEQ_CMD_RUN, 1'b0);
      @(negedge clk);
      drive(1'b0, SEQ_CMD_RUN, 1'b1);
      @(negedge clk);
      drive(1'b0, SEQ_CMD_RUN, 1'b0);
      check("halt_pc_low", 64'(pc_enable), 64'd0);
      begin
         int n = 0;
         for (int k = 0; k < 10 && pipe_enable; k++) begin
            n++;
            @(negedge clk);
         end
         check("drain_len", 64'(n), 64'd4);
      end
      check("halted_after_drain", 64'(halted), 64'd1);
      drive(1'b1, SEQ_CMD_RUN, 1'b0);
      @(negedge clk);
      drive(1'b0, SEQ_CMD_RUN, 1'b0);
      check("halted_run_ignored", 64'(obs()), 64'({SEQ_ST_HALTED, F_HALT}));
      drive(1'b1, SEQ_CMD_CLEAR, 1'b0);
      @(negedge clk);
      drive(1'b0, SEQ_CMD_RUN, 1'b0);
      check("clear_pulse", 64'(soft_reset), 64'd1);
      @(negedge clk);
      check("clear_done_out", 64'(obs()), 64'({SEQ_ST_IDLE, F_IDLE}));
      check("clear_done_cnt", 64'(cycle_count), 64'd0);

      // Asynchronous reset in the second DRAIN cycle.
      drive(1'b1, SEQ_CMD_RUN, 1'b0);
      @(negedge clk);
      drive(1'b0, SEQ_CMD_RUN, 1'b1);
      @(negedge clk);
      drive(1'b0, SEQ_CMD_RUN, 1'b0);
      check("drain1_state", 64'(state), 64'(SEQ_ST_DRAIN));
      @(negedge clk);
      check("drain2_state", 64'(state), 64'(SEQ_ST_DRAIN));
      #2 reset = 1'b1;
      #1;
      check("async_reset_out", 64'(obs()), 64'({SEQ_ST_IDLE, F_IDLE}));
      check("async_reset_cnt", 64'(cycle_count), 64'd0);
      @(negedge clk);
      check("reset_no_soft", 64'(soft_reset), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_out", 64'(obs()), 64'({SEQ_ST_IDLE, F_IDLE}));

      // Saturation on the 4-bit instance.
      sbus.cmd_valid = 1'b1;
      sbus.cmd       = SEQ_CMD_RUN;
      @(negedge clk);
      sbus.cmd_valid = 1'b0;
      repeat (14) @(negedge clk);
      check("sat_cnt14", 64'(s_count), 64'd14);
      repeat (6) @(negedge clk);
      check("sat_cnt_stick", 64'(s_count), 64'd15);
      check("sat_still_run", 64'(s_pipe), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
